// File: rtl/arith_pkg.sv
// Shared arithmetic-unit definitions: FSM state encodings and default operand width.
// Used by seq_divider (optionally built signed with DIV_SIGNED_EN) and the multiplier controller.
package arith_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } arith_state_t;

  localparam int ARITH_W     = 16;
  localparam int ARITH_CNT_W = 5;

endpackage

// File: rtl/div_trial_sub.sv
// Combinational (W+1)-bit trial subtractor for the restoring divider.
// ge is the unsigned compare a >= b, taken from the borrow of a one-bit-wider subtract.
module div_trial_sub #(
  parameter int W = 16
) (
  input  logic [W:0]   a,
  input  logic [W-1:0] b,
  output logic [W:0]   diff,
  output logic         ge
);

  logic [W+1:0] full;

  assign full = {1'b0, a} - {2'b00, b};
  assign diff = full[W:0];
  assign ge   = ~full[W+1];

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per clock, start/done handshake.
// Define DIV_SIGNED_EN for a two's-complement build with a sign-fixup (FIX) state.
//
// state   | meaning
// IDLE    | waiting for start
// CALC    | shift / trial-subtract, one quotient bit per cycle
// FIX     | signed build only: apply result signs
// DONE    | one-cycle done pulse; start here is accepted back-to-back
module seq_divider
  import arith_pkg::*;
#(
  parameter int W     = ARITH_W,
  parameter int CNT_W = ARITH_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div_by_zero
);

  arith_state_t     state;
  logic [CNT_W-1:0] cnt;
  logic [W:0]       r;
  logic [W-1:0]     q;
  logic [W-1:0]     d;
  logic [W-1:0]     dvd;
  logic [2*W:0]     rq_sh;
  logic [W:0]       diff;
  logic             ge;
  logic [W-1:0]     q_next;
  logic [W:0]       r_next;
  logic [W-1:0]     dividend_mag;
  logic [W-1:0]     divisor_mag;

`ifdef DIV_SIGNED_EN
  logic neg_q;
  logic neg_r;

  assign dividend_mag = dividend[W-1] ? -dividend : dividend;
  assign divisor_mag  = divisor[W-1]  ? -divisor  : divisor;
`else
  assign dividend_mag = dividend;
  assign divisor_mag  = divisor;
`endif

  // Shift {R,Q} left as one vector; the vacated Q LSB receives the trial result.
  assign rq_sh  = {r, q} << 1;
  assign q_next = rq_sh[W-1:0] | {{(W-1){1'b0}}, ge};
  assign r_next = ge ? diff : rq_sh[2*W:W];

  div_trial_sub #(.W(W)) u_trial_sub (
    .a    (rq_sh[2*W:W]),
    .b    (d),
    .diff (diff),
    .ge   (ge)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      r           <= '0;
      q           <= '0;
      d           <= '0;
      dvd         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state       <= ST_CALC;
            busy        <= 1'b1;
            d           <= divisor_mag;
            dvd         <= dividend;
            q           <= dividend_mag;
            r           <= '0;
            cnt         <= CNT_W'(W);
            div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_q       <= dividend[W-1] ^ divisor[W-1];
            neg_r       <= dividend[W-1];
`endif
          end else begin
            state <= ST_IDLE;
          end
        end

        ST_CALC: begin
          if (d == '0) begin
            state       <= ST_DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            quotient    <= '1;
            remainder   <= dvd;
            div_by_zero <= 1'b1;
          end else begin
            r   <= r_next;
            q   <= q_next;
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
`ifdef DIV_SIGNED_EN
              state     <= ST_FIX;
`else
              state     <= ST_DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
              quotient  <= q_next;
              remainder <= r_next[W-1:0];
`endif
            end
          end
        end

`ifdef DIV_SIGNED_EN
        ST_FIX: begin
          state     <= ST_DONE;
          busy      <= 1'b0;
          done      <= 1'b1;
          quotient  <= neg_q ? -q : q;
          remainder <= neg_r ? -r[W-1:0] : r[W-1:0];
        end
`endif

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider with hand-computed results.
// Build with DIV_SIGNED_EN defined to exercise the signed variant.
module tb_seq_divider;

  localparam int W = 16;
`ifdef DIV_SIGNED_EN
  localparam int LAT = W + 2;
`else
  localparam int LAT = W + 1;
`endif

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int checks;
  int errors;

  seq_divider #(.W(W), .CNT_W(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one cycle and wait for done; lat counts clocks from the start cycle.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output bit busy_gap);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    busy_gap = 1'b0;
    tick();
    start = 1'b0;
    lat   = 1;
    while (!done && lat < 40) begin
      if (!busy) busy_gap = 1'b1;
      tick();
      lat++;
    end
  endtask

  int lat;
  bit gap;

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) tick();
    rst = 1'b0;
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_quot", quotient, 0);
    check_val("rst_rem", remainder, 0);
    check_val("rst_dbz", div_by_zero, 0);
    tick();

    run_op(16'd7, 16'd3, lat, gap);
    check_val("7_3_lat", lat, LAT);
    check_val("7_3_quot", quotient, 2);
    check_val("7_3_rem", remainder, 1);
    check_val("7_3_dbz", div_by_zero, 0);
    check_val("7_3_busy_at_done", busy, 0);
    check_val("7_3_busy_cont", gap, 0);
    tick();
    check_val("7_3_done_pulse", done, 0);
    check_val("7_3_hold_quot", quotient, 2);

    run_op(16'd100, 16'd0, lat, gap);
    check_val("dz_lat", lat, 2);
    check_val("dz_quot", quotient, 16'hFFFF);
    check_val("dz_rem", remainder, 100);
    check_val("dz_flag", div_by_zero, 1);
    tick();

    run_op(16'd1, 16'd2, lat, gap);
    check_val("1_2_quot", quotient, 0);
    check_val("1_2_rem", remainder, 1);
    check_val("1_2_dbz_clr", div_by_zero, 0);
    tick();

    run_op(16'd0, 16'd5, lat, gap);
    check_val("0_5_quot", quotient, 0);
    check_val("0_5_rem", remainder, 0);
    tick();

    // Second start at cycle 5 with new operands must be ignored.
    dividend = 16'd50;
    divisor  = 16'd7;
    start    = 1'b1;
    tick();
    start = 1'b0;
    lat   = 1;
    while (!done && lat < 40) begin
      if (lat == 5) begin
        dividend = 16'd9;
        divisor  = 16'd2;
        start    = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
      lat++;
    end
    start = 1'b0;
    check_val("ign_lat", lat, LAT);
    check_val("ign_quot", quotient, 7);
    check_val("ign_rem", remainder, 1);
    tick();

    // Back-to-back: second start is presented in the DONE cycle of the first.
    run_op(16'd12, 16'd5, lat, gap);
    check_val("b2b_first_quot", quotient, 2);
    check_val("b2b_first_rem", remainder, 2);
    run_op(16'd20, 16'd6, lat, gap);
    check_val("b2b_lat", lat, LAT);
    check_val("b2b_busy_cont", gap, 0);
    check_val("b2b_quot", quotient, 3);
    check_val("b2b_rem", remainder, 2);
    tick();

    // Reset in the middle of a division aborts it.
    dividend = 16'd1000;
    divisor  = 16'd3;
    start    = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("abort_busy", busy, 0);
    check_val("abort_done", done, 0);
    check_val("abort_quot", quotient, 0);
    check_val("abort_rem", remainder, 0);
    check_val("abort_dbz", div_by_zero, 0);
    gap = 1'b0;
    repeat (25) begin
      if (done || busy) gap = 1'b1;
      tick();
    end
    check_val("abort_no_done", gap, 0);
    run_op(16'd1000, 16'd3, lat, gap);
    check_val("after_abort_lat", lat, LAT);
    check_val("after_abort_quot", quotient, 333);
    check_val("after_abort_rem", remainder, 1);
    tick();

`ifdef DIV_SIGNED_EN
    run_op(16'hFFF9, 16'd2, lat, gap);
    check_val("s_m7_2_lat", lat, 18);
    check_val("s_m7_2_quot", quotient, 16'hFFFD);
    check_val("s_m7_2_rem", remainder, 16'hFFFF);
    tick();
    run_op(16'h8000, 16'hFFFF, lat, gap);
    check_val("s_min_m1_quot", quotient, 16'h8000);
    check_val("s_min_m1_rem", remainder, 0);
    check_val("s_min_m1_dbz", div_by_zero, 0);
    tick();
    run_op(16'd7, 16'hFFFE, lat, gap);
    check_val("s_7_m2_quot", quotient, 16'hFFFD);
    check_val("s_7_m2_rem", remainder, 1);
    tick();
    run_op(16'hFFF6, 16'd0, lat, gap);
    check_val("s_dz_lat", lat, 2);
    check_val("s_dz_quot", quotient, 16'hFFFF);
    check_val("s_dz_rem", remainder, 16'hFFF6);
    check_val("s_dz_flag", div_by_zero, 1);
    tick();
`else
    run_op(16'hFFFF, 16'd1, lat, gap);
    check_val("ffff_1_quot", quotient, 16'hFFFF);
    check_val("ffff_1_rem", remainder, 0);
    tick();
    run_op(16'hFFFF, 16'hFFFF, lat, gap);
    check_val("ffff_ffff_quot", quotient, 1);
    check_val("ffff_ffff_rem", remainder, 0);
    tick();
    run_op(16'h8000, 16'h7FFF, lat, gap);
    check_val("8000_7fff_quot", quotient, 1);
    check_val("8000_7fff_rem", remainder, 1);
    tick();
    run_op(16'd65000, 16'd255, lat, gap);
    check_val("65000_255_quot", quotient, 254);
    check_val("65000_255_rem", remainder, 230);
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
